// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready mux, addressed or round-robin select,
// registered single-entry output. Optional xfer counter: STREAM_MUX_XFER_CNT_EN.
module stream_mux_rr #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           sel_mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready
`ifdef STREAM_MUX_XFER_CNT_EN
    ,
    input  logic           cnt_clr,
    output logic [15:0]    xfer_count
`endif
);

    localparam logic [SW:0] NUM = (SW+1)'(N);

    logic [N-1:0][W-1:0] in_arr;
    logic [W-1:0]        out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [SW-1:0]       last_q, last_d;
    logic                grant_vld;
    logic [SW-1:0]       grant_idx;
    logic                can_load;
    logic                accept;
    logic [SW:0]         rr_sum;
    logic [SW-1:0]       rr_cand;

    assign in_arr   = in_data;
    assign can_load = ~out_valid_q | out_ready;
    assign accept   = grant_vld & can_load;

    // Grant: addressed channel, or first valid channel after last in RR order
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_sum    = '0;
        rr_cand   = '0;
        if (!sel_mode) begin
            if (({1'b0, sel} < NUM) && in_valid[sel]) begin
                grant_vld = 1'b1;
                grant_idx = sel;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                rr_sum = {1'b0, last_q} + (SW+1)'(k);
                if (rr_sum >= NUM) begin
                    rr_sum = rr_sum - NUM;
                end
                rr_cand = rr_sum[SW-1:0];
                if (!grant_vld && in_valid[rr_cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_cand;
                end
            end
        end
    end

    // One-hot ready to the granted channel when the output can take a beat
    always_comb begin
        in_ready = '0;
        if (accept) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output stage next state: load, drain, or hold
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = in_arr[grant_idx];
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // RR pointer moves only on round-robin transfers
    always_comb begin
        last_d = last_q;
        if (accept && sel_mode) begin
            last_d = grant_idx;
        end
    end

    // State registers; pointer resets so channel 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef STREAM_MUX_XFER_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Output handshake counter; clear wins over a coincident handshake
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid_q && out_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scoreboard bench for stream_mux_rr.
// Drives directed and random traffic against a behavioural model.
module tb_stream_mux_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic           sel_mode = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           cnt_clr = 1'b0;
`ifdef STREAM_MUX_XFER_CNT_EN
    logic [15:0]    xfer_count;
`endif

    int checks = 0;
    int errors = 0;

    // model state
    int             ptr = N - 1;
    bit             mv = 0;
    logic [W-1:0]   sb[$];
    logic [N-1:0]   exp_rdy = '0;
    bit             exp_ov = 0;
    bit             chk_en = 0;
    int             mcnt = 0;

    stream_mux_rr #(.N(N), .W(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .sel_mode(sel_mode),
        .sel(sel),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef STREAM_MUX_XFER_CNT_EN
        ,
        .cnt_clr(cnt_clr),
        .xfer_count(xfer_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string nm,
                         input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [W-1:0] lane(input logic [N*W-1:0] d,
                                          input int i);
        logic [N*W-1:0] t;
        t = d >> (i * W);
        return t[W-1:0];
    endfunction

    // Grant from the rules: addressed channel, or circular search after ptr
    task automatic model_grant(input bit mode, input int s,
                               input logic [N-1:0] v,
                               output bit ok, output int g);
        ok = 0;
        g  = 0;
        if (!mode) begin
            if (s < N && bit_of(v, s)) begin
                ok = 1;
                g  = s;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (ptr + k) % N;
                if (!ok && bit_of(v, c)) begin
                    ok = 1;
                    g  = c;
                end
            end
        end
    endtask

    task automatic drive(input bit mode, input int s,
                         input logic [N-1:0] v,
                         input logic [N*W-1:0] d,
                         input bit rdy, input bit clr = 0);
        bit ok;
        int g;
        bit cl;
        @(posedge clk);
        #1;
        sel_mode  = mode;
        sel       = s[SW-1:0];
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        cnt_clr   = clr;
        model_grant(mode, s, v, ok, g);
        cl      = !mv || rdy;
        exp_ov  = mv;
        exp_rdy = (ok && cl) ? (N'(1) << g) : '0;
        if (ok && cl) begin
            sb.push_back(lane(d, g));
            mv = 1;
            if (mode) ptr = g;
        end else if (mv && rdy) begin
            mv = 0;
        end
        chk_en = 1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        chk_en = 0;
        rst_n  = 1'b0;
        #1;
        check(out_valid == 1'b0, "async_rst_valid", out_valid, 0);
        check(out_data == '0, "async_rst_data", out_data, 0);
        ptr  = N - 1;
        mv   = 0;
        mcnt = 0;
        sb.delete();
        in_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare handshake signals and pop beats as they leave
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check(in_ready == exp_rdy, "in_ready", in_ready, exp_rdy);
            check(out_valid == exp_ov, "out_valid", out_valid, exp_ov);
`ifdef STREAM_MUX_XFER_CNT_EN
            check(xfer_count == 16'(mcnt), "xfer_count", xfer_count, mcnt);
            if (cnt_clr) mcnt = 0;
            else if (out_valid && out_ready) mcnt = (mcnt + 1) % 65536;
`endif
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check(0, "sb_empty", out_data, 0);
                end else begin
                    check(out_data == sb[0], "out_data", out_data, sb[0]);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    logic [N*W-1:0] dd;
    logic [N*W-1:0] ad;

    initial begin
        #12;
        check(out_valid == 1'b0, "rst_valid", out_valid, 0);
        check(out_data == '0, "rst_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // addressed mode
        ad = {8'h44, 8'h33, 8'h22, 8'h11};
        drive(0, 2, 4'b0100, ad, 1);
        drive(0, 1, 4'b0100, ad, 1);
        @(negedge clk);
        check(out_data == 8'h33, "addr_data", out_data, 8'h33);
        check(out_valid == 1'b1, "addr_valid", out_valid, 1);
        drive(0, 1, 4'b0100, ad, 1);
        @(negedge clk);
        check(out_valid == 1'b0, "addr_drop", out_valid, 0);

        // round-robin fairness
        for (int i = 0; i < 8; i++) begin
            dd = {8'hA3 + 8'(i), 8'hA2 + 8'(i), 8'hA1 + 8'(i), 8'hA0 + 8'(i)};
            drive(1, 0, 4'b1111, dd, 1);
        end
        for (int i = 0; i < 4; i++) begin
            dd = {8'hB3 + 8'(i), 8'hB2 + 8'(i), 8'hB1 + 8'(i), 8'hB0 + 8'(i)};
            drive(1, 0, 4'b1001, dd, 1);
        end

        // backpressure
        dd = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        drive(1, 0, 4'b1111, dd, 1);
        for (int i = 0; i < 3; i++) drive(1, 0, 4'b1111, dd, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 4'b1111, dd, 1);

        // mode switch keeps the pointer
        dd = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        drive(1, 0, 4'b0100, dd, 1);
        drive(0, 0, 4'b0001, dd, 1);
        drive(0, 0, 4'b0001, dd, 1);
        drive(1, 0, 4'b1111, dd, 1);
        drive(1, 0, 4'b0000, dd, 1);
        @(negedge clk);
        check(out_data == 8'hD3, "mode_switch", out_data, 8'hD3);

        // async reset mid-stream with output full
        drive(1, 0, 4'b1111, dd, 0);
        drive(1, 0, 4'b1111, dd, 0);
        @(negedge clk);
        check(out_valid == 1'b1, "pre_rst_full", out_valid, 1);
        do_reset();
        dd = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
        drive(1, 0, 4'b1111, dd, 1);
        drive(1, 0, 4'b0000, dd, 1);
        @(negedge clk);
        check(out_data == 8'hE0, "post_rst_ch0", out_data, 8'hE0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            dd = {$urandom, $urandom};
            drive($urandom_range(0, 1) == 1, $urandom_range(0, N - 1),
                  N'($urandom), dd, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0);
        end

`ifdef STREAM_MUX_XFER_CNT_EN
        // handshake count, clear with handshake, and 16-bit wrap
        drive(1, 0, 4'b0000, dd, 1, 1);
        drive(1, 0, 4'b0000, dd, 1, 1);
        for (int i = 0; i < 5; i++) drive(1, 0, 4'b1111, dd, 1);
        drive(1, 0, 4'b1111, dd, 1, 1);
        for (int i = 0; i < 65540; i++) drive(1, 0, 4'b1111, dd, 1);
`endif

        for (int i = 0; i < 3; i++) drive(1, 0, 4'b0000, dd, 1);
        @(negedge clk);
        check(sb.size() == 0, "drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
